// File: rtl/lcd_bus_responder_if.sv
// Character-LCD write bus plus the buffer read port and status outputs of the responder.
// The master modport is the bus driver / reader side; the slave modport is the responder.
interface lcd_bus_responder_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       busy;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       err_busy;
  logic       err_addr;

  modport master (
    output LCD_EN, LCD_RS, LCD_RW, LCD_DATA, rd_addr,
    input  rd_char, cursor, busy, cmd_valid, cmd_code, err_busy, err_addr
  );

  modport slave (
    input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA, rd_addr,
    output rd_char, cursor, busy, cmd_valid, cmd_code, err_busy, err_addr
  );
endinterface

// File: rtl/lcd_bus_responder.sv
// On-chip stand-in for an HD44780-style 16x2 panel: decodes writes on the LCD bus into a
// 32-character buffer with cursor, busy timing and sticky error flags.
module lcd_bus_responder #(
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input logic                iCLK,
  input logic                iRST_N,
  lcd_bus_responder_if.slave bus
);
  localparam int MAX_CYCLES = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

  state_t          r_state;
  logic            r_enS1, r_enS2, r_enS3;
  logic            r_rsS1, r_rsS2, r_rwS1, r_rwS2;
  logic [7:0]      r_dataS1, r_dataS2;
  logic [7:0]      r_buf [32];
  logic [4:0]      r_cursor;
  logic            r_incr;
  logic [CW-1:0]   r_count;
  logic [5:0]      r_clrIdx;
  logic            r_busy, r_cmdValid, r_errBusy, r_errAddr;
  logic [7:0]      r_cmdCode, r_rdChar;

  logic            w_strobe, w_write, w_accept, w_isClear;
  logic [4:0]      w_cursorStep;
  logic [6:0]      w_ddramAddr;

  assign w_strobe     = r_enS3 & ~r_enS2;
  assign w_write      = w_strobe & ~r_rwS2;
  assign w_accept     = w_write & ~r_busy;
  assign w_isClear    = ~r_rsS2 & (r_dataS2 == 8'h01);
  assign w_cursorStep = r_incr ? r_cursor + 5'd1 : r_cursor - 5'd1;
  assign w_ddramAddr  = r_dataS2[6:0];

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      {r_enS1, r_enS2, r_enS3} <= 3'b000;
      {r_rsS1, r_rsS2, r_rwS1, r_rwS2} <= 4'b0000;
      r_dataS1 <= 8'h00;
      r_dataS2 <= 8'h00;
    end else begin
      r_enS1   <= bus.LCD_EN;
      r_enS2   <= r_enS1;
      r_enS3   <= r_enS2;
      r_rsS1   <= bus.LCD_RS;
      r_rsS2   <= r_rsS1;
      r_rwS1   <= bus.LCD_RW;
      r_rwS2   <= r_rwS1;
      r_dataS1 <= bus.LCD_DATA;
      r_dataS2 <= r_dataS1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state    <= IDLE;
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
      r_cursor   <= 5'd0;
      r_incr     <= 1'b1;
      r_count    <= '0;
      r_clrIdx   <= 6'd32;
      r_busy     <= 1'b0;
      r_cmdValid <= 1'b0;
      r_cmdCode  <= 8'h00;
      r_errBusy  <= 1'b0;
      r_errAddr  <= 1'b0;
      r_rdChar   <= 8'h20;
    end else begin
      r_cmdValid <= 1'b0;
      r_rdChar   <= r_buf[bus.rd_addr];
      if (w_write && r_busy) r_errBusy <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_state <= EXEC;
            r_count <= EXEC_LOAD;
            if (r_rsS2) begin
              r_buf[r_cursor] <= r_dataS2;
              r_cursor        <= w_cursorStep;
            end else begin
              r_cmdValid <= 1'b1;
              r_cmdCode  <= r_dataS2;
              if (w_isClear) begin
                r_state  <= CLEAR;
                r_count  <= CLEAR_LOAD;
                r_clrIdx <= 6'd0;
                r_cursor <= 5'd0;
                r_incr   <= 1'b1;
              end else if (r_dataS2[7]) begin
                // Only the two visible 16-column windows of DDRAM map onto the buffer
                if (w_ddramAddr[6:4] == 3'b000) r_cursor <= {1'b0, w_ddramAddr[3:0]};
                else if (w_ddramAddr[6:4] == 3'b100) r_cursor <= {1'b1, w_ddramAddr[3:0]};
                else r_errAddr <= 1'b1;
              end else if (r_dataS2[7:2] == 6'b000001) begin
                r_incr <= r_dataS2[1];
              end else if (r_dataS2[7:1] == 7'b0000001) begin
                r_cursor <= 5'd0;
              end
            end
          end
        end
        EXEC, CLEAR: begin
          if (r_state == CLEAR && !r_clrIdx[5]) begin
            r_buf[r_clrIdx[4:0]] <= 8'h20;
            r_clrIdx             <= r_clrIdx + 6'd1;
          end
          if (r_count == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_char   = r_rdChar;
  assign bus.cursor    = r_cursor;
  assign bus.busy      = r_busy;
  assign bus.cmd_valid = r_cmdValid;
  assign bus.cmd_code  = r_cmdCode;
  assign bus.err_busy  = r_errBusy;
  assign bus.err_addr  = r_errAddr;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: transaction-level panel model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_lcd_bus_responder;
  localparam int EXEC_CYCLES  = 24;
  localparam int CLEAR_CYCLES = 48;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  lcd_bus_responder_if bus();

  lcd_bus_responder #(
    .EXEC_CYCLES (EXEC_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem [32];
  int         cur, busyFrom, busyDur, clrStart;
  bit         incr, errB, errA, expCmdValid, modelReady;
  logic [7:0] code, expRd;

  bit         pendValid, pendRs, pendRw;
  logic [7:0] pendData;
  int         pendAt;

  bit         forceEn;
  logic [4:0] forceAddr;

  function automatic bit busyAfter(int k);
    return (k >= busyFrom) && (k < busyFrom + busyDur);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    cur = 0; incr = 1'b1; busyFrom = -1000; busyDur = 0; clrStart = -1000;
    errB = 1'b0; errA = 1'b0; code = 8'h00; expCmdValid = 1'b0; expRd = 8'h20;
  endtask

  task automatic acceptWrite(bit rs, logic [7:0] data);
    int a;
    busyFrom = cyc;
    busyDur  = EXEC_CYCLES;
    if (rs) begin
      mem[cur] = data;
      cur = (cur + (incr ? 1 : 31)) % 32;
    end else begin
      code = data;
      expCmdValid = 1'b1;
      a = int'(data) % 128;
      if (data == 8'h01) begin
        busyDur = CLEAR_CYCLES; clrStart = cyc; cur = 0; incr = 1'b1;
      end else if (data >= 8'h80) begin
        if (a < 16) cur = a;
        else if (a >= 8'h40 && a < 8'h50) cur = 16 + a - 8'h40;
        else errA = 1'b1;
      end else if (data >= 8'h04 && data < 8'h08) begin
        incr = data[1];
      end else if (data >= 8'h02 && data < 8'h04) begin
        cur = 0;
      end
    end
  endtask

  // Model advances on each rising edge; the panel effect lands three edges after EN falls
  always @(posedge iCLK) begin
    cyc++;
    if (!iRST_N) begin
      modelReset();
      pendValid  = 1'b0;
      modelReady = 1'b1;
    end else begin
      expRd = mem[bus.rd_addr];
      expCmdValid = 1'b0;
      if (cyc - clrStart - 1 >= 0 && cyc - clrStart - 1 < 32) mem[cyc - clrStart - 1] = 8'h20;
      if (pendValid && pendAt == cyc) begin
        pendValid = 1'b0;
        if (!pendRw) begin
          if (busyAfter(cyc - 1)) errB = 1'b1;
          else acceptWrite(pendRs, pendData);
        end
      end
    end
  end

  always @(negedge iCLK) begin
    if (modelReady) begin
      checkOutput("rd_char",   bus.rd_char,   expRd);
      checkOutput("cursor",    bus.cursor,    cur);
      checkOutput("busy",      bus.busy,      busyAfter(cyc));
      checkOutput("cmd_valid", bus.cmd_valid, expCmdValid);
      checkOutput("cmd_code",  bus.cmd_code,  code);
      checkOutput("err_busy",  bus.err_busy,  errB);
      checkOutput("err_addr",  bus.err_addr,  errA);
    end
    bus.rd_addr = forceEn ? forceAddr : 5'($urandom_range(0, 31));
  end

  // One bus strobe; target > 0 pins the edge at which the write takes effect
  task automatic applyStimulus(input bit rs, input bit rw, input logic [7:0] data,
                               input int target, output int effEdge);
    int tgt;
    @(posedge iCLK); #1;
    bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_DATA = data;
    tgt = (target - 3 > cyc + 2) ? target - 3 : cyc + 2;
    while (cyc < tgt) begin @(posedge iCLK); #1; end
    bus.LCD_EN = 1'b0;
    pendRs = rs; pendRw = rw; pendData = data; pendAt = cyc + 3; pendValid = 1'b1;
    effEdge = cyc + 3;
    repeat (2) @(posedge iCLK);
    #1 bus.LCD_EN = 1'b1;
    @(posedge iCLK); #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge iCLK);
    while (bus.busy && n < CLEAR_CYCLES + 50) begin @(negedge iCLK); n++; end
    checkOutput("idle wait", bus.busy, 1'b0);
  endtask

  task automatic measureBusy(output int n);
    n = 0;
    @(negedge iCLK);
    while (bus.busy && n < CLEAR_CYCLES + 50) begin n++; @(negedge iCLK); end
  endtask

  task automatic peek(input logic [4:0] addr, input logic [7:0] exp, input string name);
    forceAddr = addr; forceEn = 1'b1;
    @(negedge iCLK);
    @(posedge iCLK); #1;
    checkOutput(name, bus.rd_char, exp);
    forceEn = 1'b0;
  endtask

  task automatic applyReset();
    @(posedge iCLK); #1 iRST_N = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e, e2, n, r;
    logic [7:0] d;
    bus.LCD_EN = 1'b1; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
    bus.rd_addr = 5'd0; forceEn = 1'b0; forceAddr = 5'd0; pendValid = 1'b0;
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;

    checkOutput("reset cursor", bus.cursor, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset err_busy", bus.err_busy, 0);
    checkOutput("reset err_addr", bus.err_addr, 0);
    for (int i = 0; i < 32; i++) peek(5'(i), 8'h20, "reset buffer");

    applyStimulus(0, 0, 8'h80, 0, e); waitIdle();
    applyStimulus(1, 0, 8'h41, 0, e);
    measureBusy(n);
    checkOutput("exec busy length", n, EXEC_CYCLES);
    peek(5'd0, 8'h41, "data write");
    checkOutput("cursor after write", bus.cursor, 1);

    applyStimulus(0, 0, 8'hCF, 0, e); waitIdle();
    applyStimulus(1, 0, 8'h5A, 0, e); waitIdle();
    peek(5'd31, 8'h5A, "line2 last");
    checkOutput("cursor wrap up", bus.cursor, 0);
    applyStimulus(0, 0, 8'h04, 0, e); waitIdle();
    applyStimulus(1, 0, 8'h51, 0, e); waitIdle();
    peek(5'd0, 8'h51, "decrement write");
    checkOutput("cursor wrap down", bus.cursor, 31);

    applyStimulus(0, 0, 8'h06, 0, e); waitIdle();
    applyStimulus(0, 0, 8'h80, 0, e); waitIdle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 8'h30 + 8'(i), 0, e); waitIdle();
    end
    peek(5'd3, 8'h33, "text before clear");
    applyStimulus(0, 0, 8'h01, 0, e);
    checkOutput("clear cmd_valid", bus.cmd_valid, 1);
    checkOutput("clear cursor", bus.cursor, 0);
    measureBusy(n);
    checkOutput("clear busy length", n, CLEAR_CYCLES);
    checkOutput("clear cmd_valid low", bus.cmd_valid, 0);
    checkOutput("clear cmd_code", bus.cmd_code, 8'h01);
    for (int i = 0; i < 32; i++) peek(5'(i), 8'h20, "cleared buffer");

    applyStimulus(0, 0, 8'h80, 0, e);
    applyStimulus(1, 0, 8'h77, 0, e2);
    checkOutput("collision err_busy", bus.err_busy, 1);
    waitIdle();
    peek(5'd0, 8'h20, "collision dropped");
    checkOutput("collision cursor", bus.cursor, 0);
    checkOutput("err_busy sticky", bus.err_busy, 1);

    applyReset();
    applyStimulus(0, 0, 8'h80, 0, e);
    applyStimulus(1, 0, 8'h44, e + EXEC_CYCLES + 1, e2);
    checkOutput("first idle strobe err", bus.err_busy, 0);
    checkOutput("first idle strobe cursor", bus.cursor, 1);
    applyStimulus(1, 0, 8'h45, e2 + EXEC_CYCLES, e);
    checkOutput("last busy cycle err", bus.err_busy, 1);
    checkOutput("last busy cycle cursor", bus.cursor, 1);
    waitIdle();

    applyStimulus(0, 0, 8'h85, 0, e); waitIdle();
    applyStimulus(0, 0, 8'h95, 0, e);
    checkOutput("bad addr flag", bus.err_addr, 1);
    checkOutput("bad addr cursor", bus.cursor, 5);
    waitIdle();
    applyStimulus(0, 1, 8'hC3, 0, e);
    checkOutput("read strobe cursor", bus.cursor, 5);
    checkOutput("read strobe code", bus.cmd_code, 8'h95);
    checkOutput("read strobe busy", bus.busy, 0);

    applyStimulus(0, 0, 8'hC9, 0, e); waitIdle();
    applyStimulus(1, 0, 8'h41, 0, e); waitIdle();
    applyStimulus(0, 0, 8'h01, 0, e);
    repeat (10) @(posedge iCLK);
    #1 iRST_N = 1'b0;
    @(posedge iCLK); #1;
    checkOutput("mid-clear reset busy", bus.busy, 0);
    checkOutput("mid-clear reset cursor", bus.cursor, 0);
    checkOutput("mid-clear reset code", bus.cmd_code, 8'h00);
    checkOutput("mid-clear reset err_busy", bus.err_busy, 0);
    checkOutput("mid-clear reset err_addr", bus.err_addr, 0);
    checkOutput("mid-clear reset rd_char", bus.rd_char, 8'h20);
    @(posedge iCLK); #1 iRST_N = 1'b1;
    repeat (3) @(posedge iCLK);
    #1;
    peek(5'd25, 8'h20, "reset refills buffer");

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        applyReset();
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          d = 8'($urandom);
          applyStimulus(1, ($urandom_range(0, 9) == 0), d,
                        ($urandom_range(0, 9) == 0) ? e + EXEC_CYCLES - 1 + $urandom_range(0, 2) : 0, e);
        end else begin
          case ($urandom_range(0, 9))
            0:       d = 8'h01;
            1:       d = 8'h02 | 8'($urandom_range(0, 1));
            2:       d = 8'h04 | 8'($urandom_range(0, 3));
            3, 4:    d = 8'h80 | 8'($urandom_range(0, 15));
            5, 6:    d = 8'hC0 | 8'($urandom_range(0, 15));
            7:       d = 8'h80 | 8'($urandom_range(0, 127));
            default: d = 8'($urandom);
          endcase
          applyStimulus(0, ($urandom_range(0, 9) == 0), d, 0, e);
        end
        if ($urandom_range(0, 9) < 6) waitIdle();
        else repeat ($urandom_range(0, 6)) @(posedge iCLK);
      end
    end
    waitIdle();
    repeat (4) @(posedge iCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
